// File: rtl/dlsc_pcie_s6_outbound_write_alloc_mc_pkg.sv
// Shared constants, types and helpers for the multi-channel posted-write allocator.
package dlsc_pcie_s6_outbound_write_alloc_mc_pkg;

   // Credit select value asking the core for transmit-side credits available
   localparam logic [2:0]  FC_SEL_TX_AVAIL = 3'b100;

   localparam int unsigned LEN_W   = 10;   // TLP length field, 0 encodes 1024 DWs
   localparam int unsigned BEAT_W  = 11;   // beat counter holds 1..1024
   localparam int unsigned DCRED_W = 9;    // data credits for one TLP, 1..256
   localparam int unsigned HOLD_W  = 4;    // post-TLP hold-off counter

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   // Per-channel header attributes carried alongside the address
   typedef struct packed {
      logic [LEN_W-1:0] len;
      logic [3:0]       be_first;
      logic [3:0]       be_last;
   } hdr_attr_t;

   // Posted data credits (16 bytes each) needed for a TLP of len DWs
   function automatic logic [DCRED_W-1:0] dcred_from_len(input logic [LEN_W-1:0] len);
      logic [BEAT_W-1:0] dws;
      dws = (len == '0) ? BEAT_W'(1024) : BEAT_W'(len);
      return DCRED_W'((dws + BEAT_W'(3)) >> 2);
   endfunction

   // Number of payload beats for a TLP of len DWs
   function automatic logic [BEAT_W-1:0] beats_from_len(input logic [LEN_W-1:0] len);
      return (len == '0) ? BEAT_W'(1024) : BEAT_W'(len);
   endfunction

endpackage

// File: rtl/dlsc_pcie_s6_outbound_write_alloc_mc_rr_arbiter.sv
// Round-robin arbiter: first requesting channel after the pointer, wrapping.
module dlsc_pcie_s6_outbound_write_alloc_mc_rr_arbiter #(
   parameter  int unsigned CHANNELS = 2,
   localparam int unsigned IW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic [CHANNELS-1:0] req,
   input  logic [IW-1:0]       ptr,
   output logic [CHANNELS-1:0] grant_c,
   output logic [IW-1:0]       idx_c,
   output logic                any_c
);

   // Scan from furthest to nearest so the nearest requester after ptr wins
   always_comb begin
      logic [IW-1:0] cand;
      grant_c = '0;
      idx_c   = '0;
      cand    = '0;
      any_c   = |req;
      for (int unsigned i = CHANNELS; i >= 1; i--) begin
         cand = IW'((32'(ptr) + i) % CHANNELS);
         if (req[cand]) begin
            idx_c = cand;
         end
      end
      grant_c[idx_c] = any_c;
   end

endmodule

// File: rtl/dlsc_pcie_s6_outbound_write_alloc_mc.sv
// Posted-write credit allocator: picks a channel whose next TLP fits the
// available posted credits, forwards its header then payload, then holds off
// while the core's credit counters catch up.
module dlsc_pcie_s6_outbound_write_alloc_mc
   import dlsc_pcie_s6_outbound_write_alloc_mc_pkg::*;
#(
   parameter  int unsigned CHANNELS = 2,
   parameter  int unsigned ADDR     = 32,
   parameter  int unsigned FCHB     = 8,
   parameter  int unsigned FCDB     = 12,
   parameter  int unsigned HDR_RSV  = 0,
   parameter  int unsigned DATA_RSV = 0,
   parameter  int unsigned HOLDOFF  = 4,
   localparam int unsigned CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int unsigned AW       = ADDR - 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     dma_en,

   output logic [2:0]               fc_sel,
   input  logic [FCHB-1:0]          fc_ph,
   input  logic [FCDB-1:0]          fc_pd,

   output logic [CHANNELS-1:0]      tlp_h_ready,
   input  logic [CHANNELS-1:0]      tlp_h_valid,
   input  logic [CHANNELS*AW-1:0]   tlp_h_addr,
   input  logic [CHANNELS*10-1:0]   tlp_h_len,
   input  logic [CHANNELS*4-1:0]    tlp_h_be_first,
   input  logic [CHANNELS*4-1:0]    tlp_h_be_last,

   output logic [CHANNELS-1:0]      tlp_d_ready,
   input  logic [CHANNELS-1:0]      tlp_d_valid,
   input  logic [CHANNELS*32-1:0]   tlp_d_data,

   input  logic                     wr_tlp_h_ready,
   output logic                     wr_tlp_h_valid,
   output logic [AW-1:0]            wr_tlp_h_addr,
   output logic [9:0]               wr_tlp_h_len,
   output logic [3:0]               wr_tlp_h_be_first,
   output logic [3:0]               wr_tlp_h_be_last,
   output logic [CHW-1:0]           wr_tlp_h_ch,

   input  logic                     wr_tlp_d_ready,
   output logic                     wr_tlp_d_valid,
   output logic [31:0]              wr_tlp_d_data,

   output logic                     busy
);

   // Compare widths: one spare bit so reserve additions never wrap
   localparam int unsigned PHW = FCHB + 1;
   localparam int unsigned PDW = (FCDB >= DCRED_W) ? FCDB + 1 : DCRED_W + 1;

   state_t              state;
   state_t              state_nxt;
   logic [CHW-1:0]      rr_ptr;
   logic [BEAT_W-1:0]   beats;
   logic [HOLD_W-1:0]   holdoff;
   logic                grant_go;
   logic                beat_go;
   logic                ph_ok;

   logic [CHANNELS-1:0] elig;
   logic [CHANNELS-1:0] arb_grant;
   logic [CHW-1:0]      arb_idx;
   logic                arb_any;

   logic [AW-1:0]       addr_arr [CHANNELS];
   hdr_attr_t           attr_arr [CHANNELS];
   logic [31:0]         data_arr [CHANNELS];
   logic [AW-1:0]       sel_addr;
   hdr_attr_t           sel_attr;

   assign fc_sel = FC_SEL_TX_AVAIL;
   assign busy   = (state != ST_IDLE);

   // Header credit check is common to all channels
   assign ph_ok = (PHW'(fc_ph) >= PHW'(1 + HDR_RSV));

   // Unflatten per-channel buses and qualify each header against credits
   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      assign addr_arr[g] = tlp_h_addr[g*AW +: AW];
      assign attr_arr[g] = {tlp_h_len[g*LEN_W +: LEN_W],
                            tlp_h_be_first[g*4 +: 4],
                            tlp_h_be_last[g*4 +: 4]};
      assign data_arr[g] = tlp_d_data[g*32 +: 32];
      assign elig[g]     = tlp_h_valid[g] & ph_ok &
                           (PDW'(fc_pd) >= PDW'(dcred_from_len(attr_arr[g].len)) + PDW'(DATA_RSV));
   end

   dlsc_pcie_s6_outbound_write_alloc_mc_rr_arbiter #(
      .CHANNELS (CHANNELS)
   ) u_arb (
      .req     (elig),
      .ptr     (rr_ptr),
      .grant_c (arb_grant),
      .idx_c   (arb_idx),
      .any_c   (arb_any)
   );

   // One-hot AND-OR select of the winning channel's header
   always_comb begin
      sel_addr = '0;
      sel_attr = '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         if (arb_grant[c]) begin
            sel_addr = sel_addr | addr_arr[c];
            sel_attr = hdr_attr_t'(sel_attr | attr_arr[c]);
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and handshake steering
   always_comb begin
      state_nxt      = state;
      grant_go       = 1'b0;
      beat_go        = 1'b0;
      tlp_h_ready    = '0;
      tlp_d_ready    = '0;
      wr_tlp_h_valid = 1'b0;
      wr_tlp_d_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            if (dma_en && arb_any) begin
               grant_go  = 1'b1;
               state_nxt = ST_HDR;
            end
         end
         ST_HDR: begin
            wr_tlp_h_valid = 1'b1;
            if (wr_tlp_h_ready) begin
               tlp_h_ready[wr_tlp_h_ch] = 1'b1;
               state_nxt                = ST_DATA;
            end
         end
         ST_DATA: begin
            wr_tlp_d_valid           = tlp_d_valid[wr_tlp_h_ch];
            tlp_d_ready[wr_tlp_h_ch] = wr_tlp_d_ready;
            beat_go                  = wr_tlp_d_ready & tlp_d_valid[wr_tlp_h_ch];
            if (beat_go && beats == BEAT_W'(1)) begin
               state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (holdoff == HOLD_W'(1)) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Header capture, round-robin pointer, beat and hold-off counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr            <= CHW'(CHANNELS - 1);
         wr_tlp_h_ch       <= '0;
         wr_tlp_h_addr     <= '0;
         wr_tlp_h_len      <= '0;
         wr_tlp_h_be_first <= '0;
         wr_tlp_h_be_last  <= '0;
         beats             <= '0;
         holdoff           <= '0;
      end else begin
         if (grant_go) begin
            rr_ptr            <= arb_idx;
            wr_tlp_h_ch       <= arb_idx;
            wr_tlp_h_addr     <= sel_addr;
            wr_tlp_h_len      <= sel_attr.len;
            wr_tlp_h_be_first <= sel_attr.be_first;
            wr_tlp_h_be_last  <= sel_attr.be_last;
            beats             <= beats_from_len(sel_attr.len);
         end
         if (beat_go) begin
            beats <= beats - BEAT_W'(1);
         end
         if (state == ST_DATA && state_nxt == ST_HOLD) begin
            holdoff <= HOLD_W'(HOLDOFF);
         end else if (state == ST_HOLD) begin
            holdoff <= holdoff - HOLD_W'(1);
         end
      end
   end

   // Payload follows the committed channel; quiet outside the data phase
   assign wr_tlp_d_data = (state == ST_DATA) ? data_arr[wr_tlp_h_ch] : '0;

endmodule
